// File: rtl/register_writeback_if.sv
// Write-back bus: destination select, result word and carry in; the four
// architectural registers and the carry flag out.
interface register_writeback_if #(
  parameter int bitWidth = 4
);
  logic                CE;
  logic                WE;
  logic [1:0]          LD;
  logic [bitWidth-1:0] D;
  logic                CIN;
  logic [bitWidth-1:0] QA;
  logic [bitWidth-1:0] QB;
  logic [bitWidth-1:0] QOUT;
  logic [bitWidth-1:0] QPC;
  logic                CF;

  modport master (
    output CE, WE, LD, D, CIN,
    input  QA, QB, QOUT, QPC, CF
  );

  modport slave (
    input  CE, WE, LD, D, CIN,
    output QA, QB, QOUT, QPC, CF
  );
endinterface

// File: rtl/register_writeback.sv
// Register file write side: loads one of A/B/OUT/PC from the result word,
// advances PC when it is not the destination, and latches carry every step.
module register_writeback #(
  parameter int bitWidth = 4
) (
  input  logic                CLK,
  input  logic                nRESET,
  register_writeback_if.slave bus
);
  localparam logic [bitWidth-1:0] PC_STEP = {{(bitWidth-1){1'b0}}, 1'b1};

  logic [bitWidth-1:0] qa_q, qa_d;
  logic [bitWidth-1:0] qb_q, qb_d;
  logic [bitWidth-1:0] qout_q, qout_d;
  logic [bitWidth-1:0] qpc_q, qpc_d;
  logic                cf_q, cf_d;

  always_comb begin
    qa_d   = qa_q;
    qb_d   = qb_q;
    qout_d = qout_q;
    qpc_d  = qpc_q;
    cf_d   = cf_q;
    if (bus.CE) begin
      cf_d  = bus.CIN;
      qpc_d = qpc_q + PC_STEP;
      // A jump overrides the increment; jumping to the current PC is the halt idiom.
      if (bus.WE) begin
        case (bus.LD)
          2'd0:    qa_d   = bus.D;
          2'd1:    qb_d   = bus.D;
          2'd2:    qout_d = bus.D;
          default: qpc_d  = bus.D;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      qa_q   <= '0;
      qb_q   <= '0;
      qout_q <= '0;
      qpc_q  <= '0;
      cf_q   <= 1'b0;
    end else begin
      qa_q   <= qa_d;
      qb_q   <= qb_d;
      qout_q <= qout_d;
      qpc_q  <= qpc_d;
      cf_q   <= cf_d;
    end
  end

  assign bus.QA   = qa_q;
  assign bus.QB   = qb_q;
  assign bus.QOUT = qout_q;
  assign bus.QPC  = qpc_q;
  assign bus.CF   = cf_q;
endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback; each snapshot is {QA,QB,QOUT,QPC,CF}.
module tb_register_writeback;
  localparam int W = 4;

  logic CLK = 1'b0;
  logic nRESET = 1'b0;
  int   errors = 0;
  int   checks = 0;

  register_writeback_if #(.bitWidth(W)) bus();

  register_writeback #(.bitWidth(W)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (nRESET) begin
      assert (!$isunknown(bus.CE)) else $error("CE unknown out of reset");
      if (bus.CE === 1'b1)
        assert (!$isunknown({bus.WE, bus.LD})) else $error("WE/LD unknown while stepping");
    end
  end

  function automatic logic [16:0] snap();
    return {bus.QA, bus.QB, bus.QOUT, bus.QPC, bus.CF};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ce, input logic we, input logic [1:0] ld,
                       input logic [3:0] d, input logic cin);
    bus.CE  = ce;
    bus.WE  = we;
    bus.LD  = ld;
    bus.D   = d;
    bus.CIN = cin;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRESET = 1'b0;
    #1;
    @(negedge CLK);
    nRESET = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    // power-on state
    #2;
    checks++;
    if (snap() !== 17'h0) begin
      errors++; $display("FAIL por: got %h want %h", snap(), 17'h0);
    end
    @(negedge CLK);
    nRESET = 1'b1;
    drive(1'b1, 1'b1, 2'd0, 4'h5, 1'b1);
    tick();
    drive(1'b1, 1'b1, 2'd3, 4'h9, 1'b1);
    tick();
    exp = {4'h5, 4'h0, 4'h0, 4'h9, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL rst_setup: got %h want %h", snap(), exp);
    end
    // pending write of F into A must be discarded by the mid-cycle reset
    drive(1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
    #2;
    nRESET = 1'b0;
    #1;
    checks++;
    if (snap() !== 17'h0) begin
      errors++; $display("FAIL rst_async: got %h want %h", snap(), 17'h0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (snap() !== 17'h0) begin
        errors++; $display("FAIL rst_hold%0d: got %h want %h", i, snap(), 17'h0);
      end
    end
    @(negedge CLK);
    nRESET = 1'b1;
    tick();
    exp = {4'hF, 4'h0, 4'h0, 4'h1, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL rst_release: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_decode();
    logic [16:0] exp;
    do_reset();
    drive(1'b1, 1'b1, 2'd0, 4'hA, 1'b0);
    tick();
    exp = {4'hA, 4'h0, 4'h0, 4'h1, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL dec_a: got %h want %h", snap(), exp);
    end
    bus.LD = 2'd1;
    tick();
    exp = {4'hA, 4'hA, 4'h0, 4'h2, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL dec_b: got %h want %h", snap(), exp);
    end
    bus.LD = 2'd2;
    tick();
    exp = {4'hA, 4'hA, 4'hA, 4'h3, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL dec_out: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_pc_wrap();
    logic [16:0] exp;
    logic [3:0]  pc;
    do_reset();
    drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      pc  = 4'(i % 16);
      exp = {4'h0, 4'h0, 4'h0, pc, 1'b0};
      checks++;
      if (snap() !== exp) begin
        errors++; $display("FAIL pc_wrap%0d: got %h want %h", i, snap(), exp);
      end
    end
  endtask

  task automatic test_jump();
    logic [16:0] exp;
    do_reset();
    drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);
    repeat (4) tick();
    exp = {4'h0, 4'h0, 4'h0, 4'h4, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL jmp_pre: got %h want %h", snap(), exp);
    end
    drive(1'b1, 1'b1, 2'd3, 4'h2, 1'b0);
    tick();
    exp = {4'h0, 4'h0, 4'h0, 4'h2, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL jmp: got %h want %h", snap(), exp);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (snap() !== exp) begin
        errors++; $display("FAIL halt%0d: got %h want %h", i, snap(), exp);
      end
    end
  endtask

  task automatic test_carry();
    logic [16:0] exp;
    drive(1'b1, 1'b0, 2'd0, 4'h0, 1'b1);
    tick();
    exp = {4'h0, 4'h0, 4'h0, 4'h3, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL cf_set: got %h want %h", snap(), exp);
    end
    drive(1'b1, 1'b1, 2'd0, 4'h6, 1'b0);
    tick();
    exp = {4'h6, 4'h0, 4'h0, 4'h4, 1'b0};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL cf_clr: got %h want %h", snap(), exp);
    end
  endtask

  task automatic test_step_enable();
    logic [16:0] exp;
    exp = {4'h6, 4'h0, 4'h0, 4'h4, 1'b0};
    drive(1'b0, 1'b1, 2'd0, 4'h7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (snap() !== exp) begin
        errors++; $display("FAIL ce_hold%0d: got %h want %h", i, snap(), exp);
      end
    end
    bus.CE = 1'b1;
    tick();
    exp = {4'h7, 4'h0, 4'h0, 4'h5, 1'b1};
    checks++;
    if (snap() !== exp) begin
      errors++; $display("FAIL ce_step: got %h want %h", snap(), exp);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
    test_reset();
    test_decode();
    test_pc_wrap();
    test_jump();
    test_carry();
    test_step_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
